// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine: ALU control codes,
// FSM state encoding and the divide-by-zero result constant.
package muldiv_pkg;

  localparam logic [5:0] ALU_MFHI  = 6'd16;
  localparam logic [5:0] ALU_MTHI  = 6'd17;
  localparam logic [5:0] ALU_MFLO  = 6'd18;
  localparam logic [5:0] ALU_MTLO  = 6'd19;
  localparam logic [5:0] ALU_MULT  = 6'd24;
  localparam logic [5:0] ALU_MULTU = 6'd25;
  localparam logic [5:0] ALU_DIV   = 6'd26;
  localparam logic [5:0] ALU_DIVU  = 6'd27;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Divide by zero: LO is filled with this bit, HI returns the raw dividend.
  localparam logic DBZ_LO_FILL = 1'b1;

  function automatic logic isMulDivCode(input logic [5:0] code);
    return (code inside {ALU_MFHI, ALU_MTHI, ALU_MFLO, ALU_MTLO,
                         ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU});
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
interface muldiv_hilo_unit_if #(parameter int WIDTH = 32);

  logic             valid;
  logic [5:0]       alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output valid, alu_ctrl, src_a, src_b, flush,
    input  busy, stall, done, hi, lo, mf_data
  );

  modport slave (
    input  valid, alu_ctrl, src_a, src_b, flush,
    output busy, stall, done, hi, lo, mf_data
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational result correction: turns unsigned magnitudes from the iterative
// datapath into the final signed HI/LO values, including the divide-by-zero case.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_isDiv,
  input  logic               i_divZero,
  input  logic               i_negRes,
  input  logic               i_negRem,
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [WIDTH-1:0]   i_quot,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic [WIDTH-1:0]   i_srcA,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic [2*WIDTH-1:0] w_prod;

  always_comb begin
    w_prod = i_negRes ? -i_prod : i_prod;
    o_hi   = w_prod[2*WIDTH-1:WIDTH];
    o_lo   = w_prod[WIDTH-1:0];
    if (i_isDiv) begin
      // Divide by zero bypasses sign correction entirely.
      if (i_divZero) begin
        o_lo = {WIDTH{DBZ_LO_FILL}};
        o_hi = i_srcA;
      end else begin
        o_lo = i_negRes ? -i_quot : i_quot;
        o_hi = i_negRem ? -i_rem  : i_rem;
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Radix-2 iterative multiply/divide engine owning HI/LO, with EX-stage stall.
// Optional macro MULDIV_EARLY_TERM_EN: finish a multiply once the remaining multiplier bits are zero.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               rst_n,
  muldiv_hilo_unit_if.slave bus
);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_srcA;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_isDiv;
  logic               r_divZero;
  logic               r_negRes;
  logic               r_negRem;

  logic               w_signedOp;
  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH-1:0]   w_divDiff;
  logic               w_divGe;
  logic               w_mulRemZero;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;
  logic [WIDTH-1:0]   w_mfData;

  assign w_signedOp = (bus.alu_ctrl == ALU_MULT) || (bus.alu_ctrl == ALU_DIV);
  assign w_signA    = w_signedOp & bus.src_a[WIDTH-1];
  assign w_signB    = w_signedOp & bus.src_b[WIDTH-1];
  assign w_magA     = w_signA ? -bus.src_a : bus.src_a;
  assign w_magB     = w_signB ? -bus.src_b : bus.src_b;

  // Multiplier sits in the low half of the accumulator and is consumed LSB first.
  assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : '0)};

  assign w_divShift = {r_rem, r_quo[WIDTH-1]};
  assign w_divGe    = (w_divShift >= {1'b0, r_dvsr});
  assign w_divDiff  = w_divShift[WIDTH-1:0] - r_dvsr;

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] w_remMask;
  assign w_remMask    = ~({WIDTH{1'b1}} << r_cnt);
  assign w_mulRemZero = ((r_acc[WIDTH-1:0] & w_remMask) == '0);
`else
  assign w_mulRemZero = 1'b0;
`endif

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_signFix (
    .i_isDiv   (r_isDiv),
    .i_divZero (r_divZero),
    .i_negRes  (r_negRes),
    .i_negRem  (r_negRem),
    .i_prod    (r_acc),
    .i_quot    (r_quo),
    .i_rem     (r_rem),
    .i_srcA    (r_srcA),
    .o_hi      (w_fixHi),
    .o_lo      (w_fixLo)
  );

  // DONE also accepts new requests: busy is low there, so the pipeline will not re-present them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
      r_srcA    <= '0;
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_divZero <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (bus.valid) begin
              case (bus.alu_ctrl)
                ALU_MULT, ALU_MULTU: begin
                  r_state  <= ST_MUL;
                  r_busy   <= 1'b1;
                  r_isDiv  <= 1'b0;
                  r_acc    <= {{WIDTH{1'b0}}, w_magB};
                  r_mcand  <= w_magA;
                  r_cnt    <= CNT_W'(WIDTH);
                  r_negRes <= w_signA ^ w_signB;
                  r_negRem <= w_signA;
                end
                ALU_DIV, ALU_DIVU: begin
                  r_state   <= ST_DIV;
                  r_busy    <= 1'b1;
                  r_isDiv   <= 1'b1;
                  r_quo     <= w_magA;
                  r_rem     <= '0;
                  r_dvsr    <= w_magB;
                  r_srcA    <= bus.src_a;
                  r_divZero <= (bus.src_b == '0);
                  r_cnt     <= CNT_W'(WIDTH);
                  r_negRes  <= w_signA ^ w_signB;
                  r_negRem  <= w_signA;
                end
                ALU_MTHI: r_hi <= bus.src_a;
                ALU_MTLO: r_lo <= bus.src_a;
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            if (r_cnt == '0) begin
              r_state <= ST_FIX;
            end else if (w_mulRemZero) begin
              r_acc   <= r_acc >> r_cnt;
              r_cnt   <= '0;
              r_state <= ST_FIX;
            end else begin
              r_acc <= {w_mulSum, r_acc[WIDTH-1:1]};
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_DIV: begin
            if (r_cnt == '0) begin
              r_state <= ST_FIX;
            end else begin
              r_rem <= w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], w_divGe};
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_FIX: begin
            r_hi    <= w_fixHi;
            r_lo    <= w_fixLo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_mfData = '0;
    if (bus.alu_ctrl == ALU_MFHI) begin
      w_mfData = r_hi;
    end else if (bus.alu_ctrl == ALU_MFLO) begin
      w_mfData = r_lo;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.mf_data = w_mfData;
  assign bus.stall   = bus.valid & r_busy & isMulDivCode(bus.alu_ctrl);

endmodule
